// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_WIDTH     = 12;
    localparam int MEM_ARB_ADDR_SIZE = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational requester picker for mem_port_arbiter.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise D always beats IF.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  gnt_t last_gnt,
    output gnt_t gnt
);

`ifdef MEM_ARB_RR_EN
    // On a tie, serve whoever was not served last.
    always_comb begin
        gnt = GNT_IF;
        if (d_req && if_req) begin
            gnt = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
        end else if (d_req) begin
            gnt = GNT_D;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        gnt = GNT_IF;
        if (d_req) begin
            gnt = GNT_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data requests onto the single-port unified Memory.
// Define MEM_ARB_RR_EN to replace fixed D-over-IF priority with round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = MEM_ARB_WIDTH,
    parameter int ADDR_SIZE = MEM_ARB_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic                 if_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [WIDTH-1:0]     d_wdata,
    output logic                 d_ack,
    output logic [WIDTH-1:0]     rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wrData,
    input  logic [WIDTH-1:0]     mem_rdData
);

    state_t                state_q, state_d;
    gnt_t                  gnt_q, gnt_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic                  we_q, we_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    gnt_t                  pick;
    gnt_t                  last_gnt;

`ifdef MEM_ARB_RR_EN
    gnt_t last_gnt_q, last_gnt_d;

    // Starts at IF so that D wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= GNT_IF;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (state_q == IDLE && (if_req || d_req)) begin
            last_gnt_d = pick;
        end
    end

    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = GNT_IF;
`endif

    mem_arb_grant u_grant (
        .if_req   (if_req),
        .d_req    (d_req),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ACCESS;
                    gnt_d   = pick;
                    if (pick == GNT_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d = if_addr;
                        we_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    rdata_d = mem_rdData;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from state so an async reset kills a pending write immediately.
    assign mem_read   = (state_q == ACCESS) && !we_q;
    assign mem_write  = (state_q == ACCESS) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wrData = wdata_q;
    assign rdata      = rdata_q;
    assign if_ack     = (state_q == RESP) && (gnt_q == GNT_IF);
    assign d_ack      = (state_q == RESP) && (gnt_q == GNT_D);

endmodule
